// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
// The PARITY state is only ever entered when PISO_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  // Bit counter width able to hold 0..width-1 (never narrower than one bit).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out handshake bundle for piso_serializer.
// master = word producer and serial consumer, slave = the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_parity.sv
// Combinational even-parity reducer: o_parity is the XOR of all WIDTH bits.
// Built as an explicit XOR chain so each stage maps onto a simple LUT cascade.
module piso_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  logic [WIDTH:0] w_chain;

  assign w_chain[0] = 1'b0;

  // One XOR stage per data bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_xor
    assign w_chain[gi+1] = w_chain[gi] ^ i_data[gi];
  end

  assign o_parity = w_chain[WIDTH];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a valid/ready word interface.
// A word accepted on a rising edge is shifted out one bit per cycle starting
// in the next cycle; done pulses on the last bit of the frame, where a new
// word may be accepted so frames can run back to back with no gap.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit to
// every frame (frame length WIDTH+1 instead of WIDTH).
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               reset,
  piso_serializer_if.slave   bus
);
  import piso_pkg::*;

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  piso_state_t      r_state;
  piso_state_t      w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;

  logic [WIDTH-1:0] w_shifted;
  logic             w_data_bit;
  logic             w_last_bit;
  logic             w_final;
  logic             w_din_ready;
  logic             w_xfer;
  logic             w_sout;
  logic             w_sout_valid;
  logic             w_busy;
  logic             w_done;

  // The register always presents the next bit at the same end, so the
  // outgoing bit is a fixed tap and each step is a one-place shift.
  assign w_shifted  = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                       : {1'b0, r_shift[WIDTH-1:1]};
  assign w_data_bit = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_last_bit = (r_cnt == LAST_CNT);

`ifdef PISO_PARITY_EN
  logic r_par;
  logic w_par_next;
  logic w_din_par;

  // Parity is taken from the word as it is accepted; the shift register
  // no longer holds the whole word by the time the parity bit is sent.
  piso_parity #(.WIDTH(WIDTH)) u_parity (
    .i_data   (bus.din),
    .o_parity (w_din_par)
  );

  assign w_final = (r_state == PARITY);
`else
  assign w_final = (r_state == SHIFT) && w_last_bit;
`endif

  // Ready depends only on registered state, so the transfer decision never
  // feeds back into itself through the next-state logic.
  assign w_din_ready = (r_state == IDLE) || w_final;
  assign w_xfer      = bus.din_valid && w_din_ready;

  // Next-state, datapath update and frame outputs.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_sout       = 1'b0;
    w_sout_valid = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
`ifdef PISO_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_state_next = IDLE;
      end
      SHIFT: begin
        w_sout       = w_data_bit;
        w_sout_valid = 1'b1;
        w_busy       = 1'b1;
        if (!w_last_bit) begin
          w_shift_next = w_shifted;
          w_cnt_next   = r_cnt + CW'(1);
        end else begin
`ifdef PISO_PARITY_EN
          w_state_next = PARITY;
`else
          w_done       = 1'b1;
          w_state_next = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        w_sout       = r_par;
        w_sout_valid = 1'b1;
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // A transfer is only possible in IDLE or on the final bit; either way
    // it starts a fresh frame in the next cycle.
    if (w_xfer) begin
      w_state_next = SHIFT;
      w_shift_next = bus.din;
      w_cnt_next   = '0;
`ifdef PISO_PARITY_EN
      w_par_next   = w_din_par;
`endif
    end
  end

  // State and datapath registers; reset wins over any simultaneous transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_next;
`endif
    end
  end

  assign bus.din_ready  = w_din_ready;
  assign bus.sout       = w_sout;
  assign bus.sout_valid = w_sout_valid;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: one MSB-first and one LSB-first instance
// fed identical stimulus, checked cycle by cycle against a queue-of-bits
// reference model (each accepted word appends its frame bits to a queue;
// the head of the queue is the bit expected on sout this cycle).
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = W + PAR;

  logic clk = 1'b0;
  logic reset;

  piso_serializer_if #(.WIDTH(W)) bus_m ();
  piso_serializer_if #(.WIDTH(W)) bus_l ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [31:0] seq_m;
  logic [31:0] seq_l;

  bit q_m[$];
  bit q_l[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model: a frame is the data bits in shift order, then the parity bit.
  task automatic push_frame(input logic [7:0] w);
    for (int i = 0; i < W; i++) begin
      q_m.push_back(w[W-1-i]);
      q_l.push_back(w[i]);
    end
    if (PAR != 0) begin
      q_m.push_back(^w);
      q_l.push_back(^w);
    end
  endtask

  // Drive one cycle, check both DUTs mid-cycle, then advance the model.
  task automatic run_cycle(input logic v, input logic [7:0] d, input logic rst, input string name);
    bit ev, ef, em, el, rdy;
    reset           = rst;
    bus_m.din_valid = v;
    bus_m.din       = d;
    bus_l.din_valid = v;
    bus_l.din       = d;
    @(negedge clk);
    ev  = (q_m.size() != 0);
    ef  = (q_m.size() == 1);
    em  = ev ? q_m[0] : 1'b0;
    el  = ev ? q_l[0] : 1'b0;
    rdy = !ev || ef;
    chk($sformatf("%s c%0d sout_m", name, cyc),       32'(bus_m.sout),       32'(em));
    chk($sformatf("%s c%0d sout_valid_m", name, cyc), 32'(bus_m.sout_valid), 32'(ev));
    chk($sformatf("%s c%0d busy_m", name, cyc),       32'(bus_m.busy),       32'(ev));
    chk($sformatf("%s c%0d done_m", name, cyc),       32'(bus_m.done),       32'(ef));
    chk($sformatf("%s c%0d din_ready_m", name, cyc),  32'(bus_m.din_ready),  32'(rdy));
    chk($sformatf("%s c%0d sout_l", name, cyc),       32'(bus_l.sout),       32'(el));
    chk($sformatf("%s c%0d sout_valid_l", name, cyc), 32'(bus_l.sout_valid), 32'(ev));
    chk($sformatf("%s c%0d busy_l", name, cyc),       32'(bus_l.busy),       32'(ev));
    chk($sformatf("%s c%0d done_l", name, cyc),       32'(bus_l.done),       32'(ef));
    chk($sformatf("%s c%0d din_ready_l", name, cyc),  32'(bus_l.din_ready),  32'(rdy));
    if (bus_m.sout_valid) seq_m = {seq_m[30:0], bus_m.sout};
    if (bus_l.sout_valid) seq_l = {seq_l[30:0], bus_l.sout};
    if (bus_m.done) done_cnt++;
    if (rst) begin
      q_m.delete();
      q_l.delete();
      $display("%s c%0d reset", name, cyc);
    end else begin
      if (ev) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (v && rdy) begin
        push_frame(d);
        $display("%s c%0d transfer din=%h", name, cyc, d);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_test();
    cyc      = 0;
    done_cnt = 0;
    seq_m    = '0;
    seq_l    = '0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rv;
    logic       rr;

    reset           = 1'b1;
    bus_m.din_valid = 1'b0;
    bus_m.din       = '0;
    bus_l.din_valid = 1'b0;
    bus_l.din       = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    start_test();
    run_cycle(1'b0, 8'h00, 1'b0, "reset_state");

    // Single 0F frame, then back to idle.
    start_test();
    run_cycle(1'b1, 8'h0F, 1'b0, "frame0F");
    for (int i = 0; i < FLEN + 1; i++) run_cycle(1'b0, 8'h00, 1'b0, "frame0F");
`ifdef PISO_PARITY_EN
    chk("frame0F bits_m", seq_m, 32'({8'h0F, 1'b0}));
    chk("frame0F bits_l", seq_l, 32'({8'hF0, 1'b0}));
`else
    chk("frame0F bits_m", seq_m, 32'h0F);
    chk("frame0F bits_l", seq_l, 32'hF0);
`endif
    chk("frame0F done_count", 32'(done_cnt), 32'd1);

    // Back-to-back: F0 offered on the final bit of the 0F frame.
    start_test();
    run_cycle(1'b1, 8'h0F, 1'b0, "b2b");
    for (int i = 1; i < FLEN; i++) run_cycle(1'b0, 8'h00, 1'b0, "b2b");
    run_cycle(1'b1, 8'hF0, 1'b0, "b2b");
    for (int i = 0; i < FLEN + 1; i++) run_cycle(1'b0, 8'h00, 1'b0, "b2b");
`ifdef PISO_PARITY_EN
    chk("b2b bits_m", seq_m, 32'({8'h0F, 1'b0, 8'hF0, 1'b0}));
    chk("b2b bits_l", seq_l, 32'({8'hF0, 1'b0, 8'h0F, 1'b0}));
`else
    chk("b2b bits_m", seq_m, 32'h0FF0);
    chk("b2b bits_l", seq_l, 32'hF00F);
`endif
    chk("b2b done_count", 32'(done_cnt), 32'd2);

    // din_valid held with FF in cycles 2-7 must not disturb the frame.
    start_test();
    run_cycle(1'b1, 8'h0F, 1'b0, "hold");
    run_cycle(1'b0, 8'h00, 1'b0, "hold");
    for (int i = 2; i <= 7; i++) run_cycle(1'b1, 8'hFF, 1'b0, "hold");
    for (int i = 8; i <= FLEN + 1; i++) run_cycle(1'b0, 8'h00, 1'b0, "hold");
`ifdef PISO_PARITY_EN
    chk("hold bits_m", seq_m, 32'({8'h0F, 1'b0}));
`else
    chk("hold bits_m", seq_m, 32'h0F);
`endif

    // Reset in cycle 4 aborts the frame with no done pulse.
    start_test();
    run_cycle(1'b1, 8'h0F, 1'b0, "abort");
    for (int i = 1; i <= 3; i++) run_cycle(1'b0, 8'h00, 1'b0, "abort");
    run_cycle(1'b0, 8'h00, 1'b1, "abort");
    for (int i = 5; i <= FLEN + 2; i++) run_cycle(1'b0, 8'h00, 1'b0, "abort");
    chk("abort done_count", 32'(done_cnt), 32'd0);

    // 07 frame: odd weight, so parity bit is 1 when enabled.
    start_test();
    run_cycle(1'b1, 8'h07, 1'b0, "frame07");
    for (int i = 0; i < FLEN + 1; i++) run_cycle(1'b0, 8'h00, 1'b0, "frame07");
`ifdef PISO_PARITY_EN
    chk("frame07 bits_m", seq_m, 32'({8'h07, 1'b1}));
`else
    chk("frame07 bits_m", seq_m, 32'h07);
`endif

    // Reset together with an offered word: the word is dropped.
    start_test();
    run_cycle(1'b1, 8'hA5, 1'b1, "rst_xfer");
    run_cycle(1'b0, 8'h00, 1'b0, "rst_xfer");

    // Random traffic with occasional resets.
    start_test();
    for (int i = 0; i < 400; i++) begin
      rd = 8'($urandom);
      rv = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 39) == 0);
      run_cycle(rv, rd, rr, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word offered for transfer.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  serial data bit.
REQ-009 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-010 busy  output  1  a frame is being shifted out.
REQ-011 done  output  1  single-cycle pulse on the final bit of a frame.

Function
REQ-012 Handshake: a word transfers on a rising edge where din_valid=1 and din_ready=1; din is ignored in all other cycles.
REQ-013 FSM states: IDLE, SHIFT, and PARITY (PARITY only when PARITY_EN is defined).
REQ-014 IDLE: din_ready=1, sout_valid=0, sout=0, busy=0, done=0; on transfer, load the shift register, clear the bit counter, go to SHIFT.
REQ-015 Latency: the first frame bit appears on sout, with sout_valid=1, in the cycle immediately after the transfer edge.
REQ-016 SHIFT: sout_valid=1, busy=1; one data bit per cycle in MSB_FIRST order; counter increments 0..WIDTH-1, sized by $clog2(WIDTH).
REQ-017 Final bit of the frame (counter=WIDTH-1 without PARITY_EN, PARITY cycle with it): done=1 and din_ready=1.
REQ-018 Back-to-back: a transfer during the final-bit cycle starts the next frame in the following cycle with no gap; without a transfer the FSM returns to IDLE.
REQ-019 din_ready=0 in every non-final SHIFT or PARITY cycle; din_valid there has no effect and the current frame is not disturbed.
REQ-020 sout=0 whenever sout_valid=0.

Reset
REQ-021 reset=1 at a rising edge forces IDLE, clears the shift register and counter, and aborts any frame in progress with no done pulse.
REQ-022 Outputs in the cycle after reset: din_ready=1, sout=0, sout_valid=0, busy=0, done=0.
REQ-023 reset takes priority over a simultaneous transfer; that word is dropped.

Configuration
REQ-024 Macro PISO_PARITY_EN defined: after the WIDTH data bits, one PARITY cycle drives the even-parity bit (XOR of the captured word) with sout_valid=1 and busy=1; the frame is WIDTH+1 cycles long.
REQ-025 Macro PISO_PARITY_EN undefined: no PARITY state or parity logic; the frame is WIDTH cycles long.

Structure
REQ-026 Shared package piso_pkg holds the FSM state typedef (IDLE, SHIFT, PARITY) and the counter-width constant function.
REQ-027 One sub-module, piso_parity: a combinational even-parity reducer over WIDTH bits, instantiated only under PISO_PARITY_EN.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, no parity: transfer 8'h0F at cycle 0 -> sout = 0,0,0,0,1,1,1,1 over cycles 1-8, sout_valid=1 for cycles 1-8, done=1 only in cycle 8, IDLE in cycle 9.
REQ-029 MSB_FIRST=0: transfer 8'h0F -> sout = 1,1,1,1,0,0,0,0 over cycles 1-8.
REQ-030 PISO_PARITY_EN: 8'h0F -> parity bit 0 in cycle 9; 8'h07 -> parity bit 1 in cycle 9; done=1 only in cycle 9.
REQ-031 Back-to-back: 8'h0F, then 8'hF0 offered during the final bit -> 16 consecutive sout_valid=1 cycles, bits 0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0, and two done pulses (cycles 8 and 16).
REQ-032 Hold din_valid=1 with din=8'hFF during cycles 2-7 of an 8'h0F frame -> the frame is unchanged and din_ready=0 in those cycles.
REQ-033 Assert reset in cycle 4 of an 8'h0F frame -> cycle 5: sout_valid=0, busy=0, din_ready=1, and no done pulse at any point.
